// File: rtl/deserializer8_pkg.sv
// deserializer8_pkg: shared state encoding, bit-order constants and default width
package deserializer8_pkg;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam logic ORDER_MSB = 1'b0;
    localparam logic ORDER_LSB = 1'b1;
endpackage

// File: rtl/deser_shift_reg.sv
// deser_shift_reg: WIDTH-bit shift register with shift enable and direction select
// Ports: clk, reset_n (async active-low), clear (sync flush to zero), shift_en,
//        dir (ORDER_LSB shifts right, ORDER_MSB shifts left), bit_in,
//        q_next (value q takes at the next edge), q (register contents)
module deser_shift_reg
    import deserializer8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             bit_in,
    output logic [WIDTH-1:0] q_next,
    output logic [WIDTH-1:0] q
);
    // q_next is exported so the top can capture a word on the same edge its last bit arrives
    always_comb q_next = !shift_en ? q :
                         (dir == ORDER_LSB) ? {bit_in, q[WIDTH-1:1]} : {q[WIDTH-2:0], bit_in};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else          q <= clear ? '0 : q_next;
    end
endmodule

// File: rtl/deserializer8.sv
// deserializer8: collects a bit-serial stream into WIDTH-bit words on a valid/ready output
// Ports: clk, reset_n (async active-low), clear (sync flush), lsb_first (order, latched on first bit),
//        bit_valid/bit_in/bit_ready (serial input handshake),
//        d_out/d_valid/d_ready (parallel output handshake),
//        parity_err (only with DESERIALIZER8_PARITY_CHECK_EN: an even-parity bit follows each word)
module deserializer8
    import deserializer8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             lsb_first,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    input  logic             d_ready
`ifdef DESERIALIZER8_PARITY_CHECK_EN
    ,
    output logic             parity_err
`endif
);
`ifdef DESERIALIZER8_PARITY_CHECK_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(NBITS + 1);
    localparam logic [CW-1:0] LAST = CW'(NBITS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             order, accept, first, done, handoff, dir, shift_en;
    logic [WIDTH-1:0] sreg, sreg_nx;

    always_comb begin
        bit_ready = (state != ST_HOLD) || d_ready;
        accept    = bit_valid && bit_ready;
        handoff   = (state == ST_HOLD) && d_ready;
        // a word starts on any accept outside COLLECT, including the no-bubble HOLD handoff
        first     = accept && (state != ST_COLLECT);
        cnt_nx    = first ? ONE : cnt + ONE;
        done      = accept && (cnt_nx == LAST);
        dir       = first ? lsb_first : order;
`ifdef DESERIALIZER8_PARITY_CHECK_EN
        shift_en  = accept && !done;
`else
        shift_en  = accept;
`endif
        state_nx  = clear ? ST_IDLE :
                    done ? ST_HOLD :
                    handoff ? (accept ? ST_COLLECT : ST_IDLE) :
                    (state == ST_IDLE && accept) ? ST_COLLECT : state;
    end

    assign d_valid = (state == ST_HOLD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            order <= ORDER_MSB;
            d_out <= '0;
        end else begin
            cnt <= clear ? '0 : accept ? cnt_nx : handoff ? '0 : cnt;
            if (!clear && first) order <= lsb_first;
            if (!clear && done)  d_out <= sreg_nx;
        end
    end

`ifdef DESERIALIZER8_PARITY_CHECK_EN
    // the parity bit is never shifted in, so sreg already holds the full data word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) parity_err <= 1'b0;
        else          parity_err <= clear ? 1'b0 : done ? (^sreg ^ bit_in) : handoff ? 1'b0 : parity_err;
    end
`endif

    deser_shift_reg #(.WIDTH(WIDTH)) u_shift (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .shift_en (shift_en),
        .dir      (dir),
        .bit_in   (bit_in),
        .q_next   (sreg_nx),
        .q        (sreg)
    );
endmodule

// File: tb/tb_deserializer8.sv
// tb_deserializer8: directed and randomized checks of deserializer8 against a bit-queue reference model
module tb_deserializer8;
`ifdef DESERIALIZER8_PARITY_CHECK_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    logic       clk = 1'b0;
    logic       reset_n, clear, lsb_first, bit_valid, bit_in, d_ready;
    logic       bit_ready, d_valid, parity_err;
    logic [7:0] d_out;
    int         n_vec = 0;
    int         n_err = 0;
    logic       m_held = 1'b0;
    logic       m_ord = 1'b0;
    logic       m_perr = 1'b0;
    logic [7:0] m_exp = 8'h00;
    logic       m_bits[$];

    always #5 clk = ~clk;

    deserializer8 #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .lsb_first  (lsb_first),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .d_out      (d_out),
        .d_valid    (d_valid),
        .d_ready    (d_ready)
`ifdef DESERIALIZER8_PARITY_CHECK_EN
        ,
        .parity_err (parity_err)
`endif
    );
`ifndef DESERIALIZER8_PARITY_CHECK_EN
    assign parity_err = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock cycle: drive at negedge, check outputs, advance the model as the posedge will
    task automatic step(input logic bv, input logic bi, input logic lsb, input logic rdy, input logic clr);
        logic       exp_ready;
        logic [7:0] w;
        logic       p;
        bit_valid = bv;
        bit_in    = bi;
        lsb_first = lsb;
        d_ready   = rdy;
        clear     = clr;
        #1;
        exp_ready = !m_held || rdy;
        check("bit_ready", {31'd0, bit_ready}, {31'd0, exp_ready});
        check("d_valid", {31'd0, d_valid}, {31'd0, m_held});
        if (m_held) check("d_out", {24'd0, d_out}, {24'd0, m_exp});
`ifdef DESERIALIZER8_PARITY_CHECK_EN
        check("parity_err", {31'd0, parity_err}, {31'd0, m_held && m_perr});
`endif
        if (clr) begin
            m_bits.delete();
            m_held = 1'b0;
        end else begin
            if (m_held && rdy) m_held = 1'b0;
            if (bv && exp_ready) begin
                if (m_bits.size() == 0) m_ord = lsb;
                m_bits.push_back(bi);
                if (m_bits.size() == NB) begin
                    w = 8'h00;
                    p = 1'b0;
                    for (int i = 0; i < 8; i++)
                        w = m_ord ? (w | (8'(m_bits[i]) << i)) : ((w << 1) | 8'(m_bits[i]));
                    for (int i = 0; i < NB; i++) p = p ^ m_bits[i];
                    m_exp  = w;
                    m_perr = p;
                    m_held = 1'b1;
                    m_bits.delete();
                end
            end
        end
        @(negedge clk);
    endtask

    // sends s left to right; gap idle cycles after each bit, lsb_first flipped from bit 3 on when gapped
    task automatic send_seq(input logic [7:0] s, input logic lsb, input logic rdy, input int gap, input logic bad_par);
        logic l;
        for (int i = 0; i < 8; i++) begin
            l = (gap > 0 && i >= 3) ? ~lsb : lsb;
            step(1'b1, s[7-i], l, rdy, 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), l, rdy, 1'b0);
        end
`ifdef DESERIALIZER8_PARITY_CHECK_EN
        step(1'b1, ^s ^ bad_par, lsb, rdy, 1'b0);
`else
        if (bad_par) step(1'b0, 1'b0, lsb, rdy, 1'b0);
`endif
    endtask

    initial begin
        reset_n   = 1'b0;
        clear     = 1'b0;
        lsb_first = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        d_ready   = 1'b0;
        @(negedge clk);
        check("rst_d_valid", {31'd0, d_valid}, 32'd0);
        check("rst_d_out", {24'd0, d_out}, 32'd0);
        check("rst_bit_ready", {31'd0, bit_ready}, 32'd1);
        check("rst_parity_err", {31'd0, parity_err}, 32'd0);
        reset_n = 1'b1;

        send_seq(8'b10100101, 1'b0, 1'b1, 0, 1'b0);
        check("a5_msb", {24'd0, d_out}, 32'hA5);
        check("a5_msb_valid", {31'd0, d_valid}, 32'd1);
        send_seq(8'b10100101, 1'b1, 1'b1, 0, 1'b0);
        check("a5_lsb", {24'd0, d_out}, 32'hA5);
        send_seq(8'b10000000, 1'b1, 1'b1, 0, 1'b0);
        check("lsb_01", {24'd0, d_out}, 32'h01);

        send_seq(8'h3C, 1'b0, 1'b1, 0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
        check("bp_hold", {24'd0, d_out}, 32'h3C);
        check("bp_ready", {31'd0, bit_ready}, 32'd0);
        send_seq(8'h5A, 1'b0, 1'b1, 0, 1'b0);
        check("bp_next_word", {24'd0, d_out}, 32'h5A);

        send_seq(8'hF0, 1'b0, 1'b1, 2, 1'b0);
        check("gap_f0", {24'd0, d_out}, 32'hF0);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_seq(8'h81, 1'b0, 1'b1, 0, 1'b0);
        check("clear_81", {24'd0, d_out}, 32'h81);

`ifdef DESERIALIZER8_PARITY_CHECK_EN
        send_seq(8'h07, 1'b0, 1'b1, 0, 1'b0);
        check("par_ok", {31'd0, parity_err}, 32'd0);
        send_seq(8'h07, 1'b0, 1'b1, 0, 1'b1);
        check("par_bad", {31'd0, parity_err}, 32'd1);
        check("par_data", {24'd0, d_out}, 32'h07);
`endif

        send_seq(8'h66, 1'b1, 1'b0, 0, 1'b0);
        check("hold_before_rst", {31'd0, d_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_hold_d_valid", {31'd0, d_valid}, 32'd0);
        check("rst_hold_d_out", {24'd0, d_out}, 32'd0);
        m_held = 1'b0;
        m_bits.delete();
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/deserializer8.md
Name: deserializer8

Overview:
- Receive-side counterpart of the 8-bit shift datapath. It collects a bit-serial stream into an 8-bit word and presents the word on a valid/ready parallel output.
- Bit order is selectable per word: LSB-first (the mirror of a right-shift emitter) or MSB-first (the mirror of a left-shift emitter).
- Sits between a serial source (shifter/serializer output) and a parallel consumer (register file write port).

Parameters:
- WIDTH, 8: word width in bits; counter width is clog2(WIDTH+1).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush; discards the partial word and any held word
- lsb_first  input  1  bit order, sampled on the first accepted bit of each word
- bit_valid  input  1  bit_in is valid this cycle
- bit_in  input  1  serial data bit
- bit_ready  output  1  block accepts a bit this cycle
- d_out  output  WIDTH  assembled word
- d_valid  output  1  d_out holds a complete word
- d_ready  input  1  consumer accepts d_out this cycle
- parity_err  output  1  only with PARITY_CHECK_EN; see Optional Feature

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values: sreg=0, d_out=0, d_valid=0, cnt=0, order=0, state=IDLE, parity_err=0.
- Accept event: bit_valid && bit_ready.
- FSM states:
  - IDLE: no bits held. bit_ready=1. On accept → COLLECT, cnt=1, order latched from lsb_first.
  - COLLECT: bit_ready=1. Each accept increments cnt. On the accept that makes cnt==WIDTH → HOLD; d_out loads the completed word; d_valid=1 the next cycle.
  - HOLD: d_valid=1. d_out is stable until handoff (d_valid && d_ready). bit_ready=d_ready.
    - Handoff without accept → IDLE, d_valid=0.
    - Handoff with accept → COLLECT, cnt=1, order re-latched. This sustains 1 bit/cycle with no bubble.
- Shift rules:
  - LSB-first: sreg <= {bit_in, sreg[WIDTH-1:1]}; the first bit ends in bit 0.
  - MSB-first: sreg <= {sreg[WIDTH-2:0], bit_in}; the first bit ends in bit WIDTH-1.
- Latency: 8th bit accepted at edge N → d_valid high after edge N, d_out valid in the same cycle.
- lsb_first changes mid-word are ignored; the latched order is used until the word completes.
- bit_in is ignored when bit_valid=0; no state change.
- clear has priority over accept and handoff. Next state is IDLE, d_valid=0, cnt=0, sreg=0. d_out keeps its last value but is don't-care while d_valid=0.
- reset_n asserted mid-word or in HOLD: immediate return to reset values; the partial word is lost.
- No overrun is possible: in HOLD with d_ready=0, bit_ready=0 backpressures the source.

Optional Feature:
- Macro: DESERIALIZER8_PARITY_CHECK_EN.
- Defined:
  - Each word is WIDTH+1 bits; the extra bit is the last bit received and is an even-parity bit over the data.
  - The counter counts to WIDTH+1. The parity bit is not shifted into sreg.
  - parity_err is valid with d_valid: 1 if the XOR of data and parity bit is 1. It is held and cleared with d_valid.
- Undefined:
  - parity_err port is absent; words are WIDTH bits.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_COLLECT=2'd1, ST_HOLD=2'd2
  - bit-order constants ORDER_MSB=1'b0, ORDER_LSB=1'b1
  - WIDTH default
- One natural sub-module: deser_shift_reg. It is the WIDTH-bit shift register with load-enable and a direction select; the top holds the FSM, counter and handshake.

Test Plan:
- MSB-first, d_ready=1, 8 consecutive bits 1,0,1,0,0,1,0,1 → d_out=8'hA5 with d_valid for one cycle after the 8th bit; bit_ready stays 1.
- LSB-first, same bit sequence → d_out=8'hA5 reversed = 8'hA5 (palindrome check). Then bits 1,0,0,0,0,0,0,0 → d_out=8'h01.
- Backpressure: word 8'h3C complete, d_ready=0 for 5 cycles with bit_valid=1 → bit_ready=0, d_out stays 8'h3C. Raise d_ready → handoff and first bit of next word accepted in the same cycle (cnt=1).
- Gaps: 8'hF0 sent MSB-first with bit_valid=0 for 2 cycles between every bit → d_out=8'hF0; toggling lsb_first after bit 3 does not change the result.
- clear after 5 bits, then a full word 8'h81 → d_out=8'h81 with no residue. reset_n low for 1 cycle in HOLD → d_valid=0 and d_out=0 immediately.
- With DESERIALIZER8_PARITY_CHECK_EN: data 8'h07 + parity 1 → parity_err=0; data 8'h07 + parity 0 → parity_err=1.
